wrr_channel_arbiter: RTL and testbench
======================================

# wrr_channel_arbiter

Weighted round-robin arbiter that shares one downstream word channel between `NIN` upstream word channels. Each requester gets a burst of up to its configured weight in consecutive words before the grant rotates. A registered output stage isolates downstream timing. It sits between the BD-to-PC producers (BDSerializer, FPGASerializer, GlobalTagParser outputs) and the PC_out FIFO. It can also merge PCParser BD words with SpikeGenerator tags on the BD-bound side.

## Interface
- `N`, 32: word width of every channel.
- `NIN`, 3: number of upstream requesters (2..8).
- `NW`, 4: weight width; weight 0 disables a requester.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it (low) clears all state immediately.
- `weights`  in  `[NIN-1:0][NW-1:0]`  per-requester burst length; sampled only at grant time.
- `out`  Channel #(N)  out  `d[N-1:0]`, `v` driven; `a` received. A transfer occurs on `v && a`.
- `in`  ChannelArray #(N, NIN)  in  `d[i]`, `v[i]` received; `a[i]` driven.
- `busy`  out  1  high while in GRANT.
- `cur_grant`  out  `$clog2(NIN)`  index of current or last grantee.

## Operation
- State machine with two states:
  - IDLE
    - Searches from round-robin pointer `ptr` upward, wrapping modulo NIN.
    - Picks the first `i` with `in.v[i]=1` and `weights[i]!=0`.
    - If found, next state is GRANT with `g=i`, and `credit` is loaded with `weights[i]`.
    - If not found, it stays in IDLE and `ptr` is unchanged.
  - GRANT
    - `in.a[g] = (!out_v_reg || out.a)`; every other `in.a[j]=0`. Combinational from state, `out_v_reg` and `out.a`.
    - On an upstream transfer (`in.v[g] && in.a[g]`), `in.d[g]` is loaded into the output register and `credit` decrements.
    - If that transfer has `credit==1`, the grant ends: next state IDLE, `ptr = g+1 mod NIN`.
    - If `in.v[g]=0` in a GRANT cycle, the grant ends early: next state IDLE, `ptr = g+1 mod NIN`, and the remaining credit is discarded.
- Output register:
  - `out.v` is set on an upstream load.
  - `out.v` is cleared on a downstream transfer without a simultaneous load.
  - A simultaneous load and drain in the same cycle keeps `out.v=1` with the new data. Throughput is 1 word/cycle.
- Weights:
  - A weight change during GRANT affects only the next grant.
  - A weight of 0 is never granted, even if it is the only valid requester.
- Bursts are at most 2^NW−1 words (weight 15 at NW=4).
- Data ordering within each requester is preserved. No word is dropped or duplicated except on reset.
- Fairness: with all requesters continuously valid, requester i receives exactly `weights[i]` words per rotation, in index order starting from `ptr`.

## Timing
- Reset values: state=IDLE, `ptr=0`, `credit=0`, `out.v=0`, `out.d=0`, all `in.a=0`, `busy=0`, `cur_grant=0`.
- Reset mid-burst: the held output word is lost and `out.v` drops asynchronously. After deassertion the arbiter restarts from `ptr=0`.
- Arbitration cost: one IDLE cycle per grant.
  - Example: `in.v[i]` rises at cycle 0 with the arbiter idle. GRANT starts at cycle 1, `in.a[i]=1` at cycle 1, and the word appears on `out` at cycle 2.
  - A back-to-back rotation costs one bubble cycle between bursts.
- Backpressure:
  - With `out.v=1` and `out.a=0`, `in.a[g]=0`; state, credit and data are held.
  - The grant is not released while stalled as long as `in.v[g]` stays high.
- Upstream must hold `d` and `v` stable until acked (Channel rule). The arbiter never deasserts `a` in a way that loses a presented word.
- `cur_grant` updates on entry to GRANT and holds through IDLE.

## Test plan
1. Single requester, `weights[0]=3`, 6 words A0..A5 continuously valid, `out.a=1` → out shows A0 A1 A2, one bubble, A3 A4 A5. `busy` is high 3 cycles, low 1, high 3.
2. All three valid continuously, weights {2,1,3} → repeating out source order 0,0,1,2,2,2. Exactly 3 bubbles per rotation. Words in order per source.
3. `weights[1]=0`, requesters 0..2 valid, weights 0/2 at 1/1 → requester 1 is never acked. Order 0,2,0,2,…
4. Requester 0 granted with weight 4. `out.a` held low for 5 cycles after the first word → `in.a[0]=0` throughout. Data is held on `out`. Resuming delivers words 2–4 with no loss or duplication.
5. Weight 8 grant; `in.v[0]` drops after 2 words while requester 2 is valid → grant ends and the next grant goes to 2. Requester 0 later gets a fresh full credit.
6. Reset driven low mid-burst with `out.v=1` → `out.v`, `busy` and all `in.a` fall immediately. After release, the first grant starts from `ptr=0`.

Source files
------------

// File: rtl/wrr_channel_arbiter.sv
// -----------------------------------------------------------------------------
// wrr_channel_arbiter
//
// Weighted round-robin arbiter that merges NIN upstream word channels onto one
// downstream channel. A granted requester may send up to weights[i] consecutive
// words before the grant rotates. The downstream side is fully registered.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-low; clears all state immediately
//   weights    per-requester burst length, sampled when a grant is issued
//   out_d/out_v/out_a   downstream channel (transfer on out_v && out_a)
//   in_d/in_v/in_a      upstream channels (transfer on in_v[i] && in_a[i])
//   busy       high while a grant is active
//   cur_grant  index of the current or most recent grantee
// -----------------------------------------------------------------------------
module wrr_channel_arbiter #(
    parameter int N   = 32,
    parameter int NIN = 3,
    parameter int NW  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NIN-1:0][NW-1:0]      weights,
    output logic [N-1:0]                out_d,
    output logic                        out_v,
    input  logic                        out_a,
    input  logic [NIN-1:0][N-1:0]       in_d,
    input  logic [NIN-1:0]              in_v,
    output logic [NIN-1:0]              in_a,
    output logic                        busy,
    output logic [$clog2(NIN)-1:0]      cur_grant
);

    localparam int GW = $clog2(NIN);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [GW-1:0]   r_ptr;
    logic [GW-1:0]   w_ptr_nxt;
    logic [GW-1:0]   r_g;
    logic [GW-1:0]   w_g_nxt;
    logic [GW-1:0]   w_g_inc;
    logic [GW-1:0]   w_pick;
    logic            w_found;
    logic [NW-1:0]   r_credit;
    logic [NW-1:0]   w_credit_nxt;
    logic            r_out_v;
    logic [N-1:0]    r_out_d;
    logic            w_take;
    logic            w_load;

    // Index base+k wrapped modulo NIN; base < NIN and k < NIN, so one
    // subtraction is enough.
    function automatic logic [GW-1:0] f_wrap_idx(input logic [GW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NIN) s = s - NIN;
        return GW'(s);
    endfunction

    assign w_g_inc = f_wrap_idx(r_g, 1);

    // Round-robin search starting at r_ptr. Iterating from the far end
    // downward lets the candidate closest to r_ptr overwrite the others.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = NIN - 1; k >= 0; k--) begin
            if (in_v[f_wrap_idx(r_ptr, k)] && (weights[f_wrap_idx(r_ptr, k)] != '0)) begin
                w_found = 1'b1;
                w_pick  = f_wrap_idx(r_ptr, k);
            end
        end
    end

    // The grantee may push whenever the output register is empty or is
    // being drained this cycle, giving one word per cycle throughput.
    always_comb begin
        in_a   = '0;
        w_take = (r_state == S_GRANT) && (!r_out_v || out_a);
        if (w_take) in_a[r_g] = 1'b1;
        w_load = w_take && in_v[r_g];
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_g_nxt      = r_g;
        w_credit_nxt = r_credit;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt  = S_GRANT;
                    w_g_nxt      = w_pick;
                    w_credit_nxt = weights[w_pick];
                end
            end
            S_GRANT: begin
                if (!in_v[r_g]) begin
                    // Requester went away: end the burst, drop leftover credit.
                    w_state_nxt  = S_IDLE;
                    w_ptr_nxt    = w_g_inc;
                    w_credit_nxt = '0;
                end else if (w_load) begin
                    w_credit_nxt = r_credit - NW'(1);
                    if (r_credit == NW'(1)) begin
                        w_state_nxt = S_IDLE;
                        w_ptr_nxt   = w_g_inc;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_g      <= '0;
            r_credit <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_g      <= w_g_nxt;
            r_credit <= w_credit_nxt;
        end
    end

    // Output register: a load wins over a drain, so a simultaneous
    // load and drain keeps out_v high with the new word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_v <= 1'b0;
            r_out_d <= '0;
        end else if (w_load) begin
            r_out_v <= 1'b1;
            r_out_d <= in_d[r_g];
        end else if (out_a) begin
            r_out_v <= 1'b0;
        end
    end

    assign out_v     = r_out_v;
    assign out_d     = r_out_d;
    assign busy      = (r_state == S_GRANT);
    assign cur_grant = r_g;

endmodule

// File: tb/tb_wrr_channel_arbiter.sv
// Directed bench for wrr_channel_arbiter (N=32, NIN=3, NW=4).
// Words are tagged {source, index}: source 0 -> 0xA, 1 -> 0xB, 2 -> 0xC.
module tb_wrr_channel_arbiter;

    localparam int N   = 32;
    localparam int NIN = 3;
    localparam int NW  = 4;
    localparam int GW  = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NIN-1:0][NW-1:0]  weights;
    logic [N-1:0]            out_d;
    logic                    out_v;
    logic                    out_a;
    logic [NIN-1:0][N-1:0]   in_d;
    logic [NIN-1:0]          in_v;
    logic [NIN-1:0]          in_a;
    logic                    busy;
    logic [GW-1:0]           cur_grant;

    always #5 clk = ~clk;

    wrr_channel_arbiter #(.N(N), .NIN(NIN), .NW(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .weights   (weights),
        .out_d     (out_d),
        .out_v     (out_v),
        .out_a     (out_a),
        .in_d      (in_d),
        .in_v      (in_v),
        .in_a      (in_a),
        .busy      (busy),
        .cur_grant (cur_grant)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [N-1:0]   src_mem [NIN][32];
    int             src_rd  [NIN];
    int             src_cnt [NIN];
    logic           src_en  [NIN];
    logic [N-1:0]   xq[$];
    logic           rec_busy [64];
    logic           rec_outv [64];
    logic [N-1:0]   rec_outd [64];
    logic [NIN-1:0] rec_ina  [64];
    logic [GW-1:0]  rec_gr   [64];
    int             cyc;

    function automatic logic [N-1:0] word(input int s, input int k);
        return {4'(10 + s), 28'(k)};
    endfunction

    task automatic clear_tb();
        for (int i = 0; i < NIN; i++) begin
            src_rd[i]  = 0;
            src_cnt[i] = 0;
            src_en[i]  = 1'b1;
        end
        xq.delete();
        cyc = 0;
    endtask

    task automatic load_src(input int i, input int n);
        for (int k = 0; k < n; k++) src_mem[i][k] = word(i, k);
        src_cnt[i] = n;
        src_rd[i]  = 0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NIN; i++) begin
            if (src_en[i] && (src_rd[i] < src_cnt[i])) begin
                in_v[i] = 1'b1;
                in_d[i] = src_mem[i][src_rd[i]];
            end else begin
                in_v[i] = 1'b0;
                in_d[i] = '0;
            end
        end
    endtask

    // One clock cycle: sample at the falling edge, retire upstream
    // handshakes just after the rising edge.
    task automatic step();
        logic ack [NIN];
        @(negedge clk);
        if (cyc < 64) begin
            rec_busy[cyc] = busy;
            rec_outv[cyc] = out_v;
            rec_outd[cyc] = out_d;
            rec_ina[cyc]  = in_a;
            rec_gr[cyc]   = cur_grant;
        end
        for (int i = 0; i < NIN; i++) ack[i] = in_v[i] && in_a[i];
        if (out_v && out_a) xq.push_back(out_d);
        @(posedge clk);
        #1;
        for (int i = 0; i < NIN; i++) if (ack[i]) src_rd[i]++;
        cyc++;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_tb();
        drive_inputs();
        out_a   = 1'b1;
        weights = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        out_a   = 1'b0;
        weights = '0;
        clear_tb();
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (out_v !== 1'b0) $display("FAIL reset_out_v: got %b expected 0", out_v); else n_pass++;
        n_chk++; if (out_d !== '0) $display("FAIL reset_out_d: got %h expected 0", out_d); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_chk++; if (in_a !== 3'b000) $display("FAIL reset_in_a: got %b expected 000", in_a); else n_pass++;
        n_chk++; if (cur_grant !== 2'd0) $display("FAIL reset_cur_grant: got %0d expected 0", cur_grant); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_single();
        logic [9:0] eb;
        logic [9:0] ev;
        eb = 10'b0011101110;
        ev = 10'b0111011100;
        weights[0] = 4'd3;
        load_src(0, 6);
        for (int c = 0; c < 10; c++) begin
            drive_inputs();
            step();
        end
        for (int c = 0; c < 10; c++) begin
            n_chk++;
            if (rec_busy[c] !== eb[c]) $display("FAIL single_busy c%0d: got %b expected %b", c, rec_busy[c], eb[c]);
            else n_pass++;
            n_chk++;
            if (rec_outv[c] !== ev[c]) $display("FAIL single_out_v c%0d: got %b expected %b", c, rec_outv[c], ev[c]);
            else n_pass++;
        end
        n_chk++;
        if (xq.size() != 6) $display("FAIL single_count: got %0d expected 6", xq.size());
        else begin
            n_pass++;
            for (int k = 0; k < 6; k++) begin
                n_chk++;
                if (xq[k] !== word(0, k)) $display("FAIL single_word%0d: got %h expected %h", k, xq[k], word(0, k));
                else n_pass++;
            end
        end
    endtask

    task automatic test_rotation();
        int es[12] = '{0, 0, 1, 2, 2, 2, 0, 0, 1, 2, 2, 2};
        int ek[12] = '{0, 1, 0, 0, 1, 2, 2, 3, 1, 3, 4, 5};
        int bubbles;
        weights[0] = 4'd2;
        weights[1] = 4'd1;
        weights[2] = 4'd3;
        for (int i = 0; i < NIN; i++) load_src(i, 12);
        for (int c = 0; c < 22; c++) begin
            drive_inputs();
            step();
        end
        n_chk++;
        if (xq.size() < 12) $display("FAIL rot_count: got %0d expected at least 12", xq.size());
        else begin
            n_pass++;
            for (int k = 0; k < 12; k++) begin
                n_chk++;
                if (xq[k] !== word(es[k], ek[k])) $display("FAIL rot_word%0d: got %h expected %h", k, xq[k], word(es[k], ek[k]));
                else n_pass++;
            end
        end
        bubbles = 0;
        for (int c = 2; c < 20; c++) if (rec_outv[c] === 1'b0) bubbles++;
        n_chk++;
        if (bubbles != 6) $display("FAIL rot_bubbles: got %0d expected 6", bubbles); else n_pass++;
    endtask

    task automatic test_zero_weight();
        int es[6] = '{0, 2, 0, 2, 0, 2};
        int ek[6] = '{0, 0, 1, 1, 2, 2};
        int a1;
        weights[0] = 4'd1;
        weights[1] = 4'd0;
        weights[2] = 4'd1;
        for (int i = 0; i < NIN; i++) load_src(i, 8);
        for (int c = 0; c < 16; c++) begin
            drive_inputs();
            step();
        end
        a1 = 0;
        for (int c = 0; c < 16; c++) if (rec_ina[c][1] !== 1'b0) a1++;
        n_chk++; if (a1 != 0) $display("FAIL zw_in_a1: got %0d acked cycles expected 0", a1); else n_pass++;
        n_chk++; if (src_rd[1] != 0) $display("FAIL zw_src1_taken: got %0d expected 0", src_rd[1]); else n_pass++;
        n_chk++;
        if (xq.size() < 6) $display("FAIL zw_count: got %0d expected at least 6", xq.size());
        else begin
            n_pass++;
            for (int k = 0; k < 6; k++) begin
                n_chk++;
                if (xq[k] !== word(es[k], ek[k])) $display("FAIL zw_word%0d: got %h expected %h", k, xq[k], word(es[k], ek[k]));
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        weights[0] = 4'd4;
        load_src(0, 4);
        for (int c = 0; c < 13; c++) begin
            out_a = (c >= 2 && c <= 6) ? 1'b0 : 1'b1;
            drive_inputs();
            step();
        end
        for (int c = 2; c <= 6; c++) begin
            n_chk++;
            if (rec_ina[c][0] !== 1'b0) $display("FAIL bp_in_a c%0d: got %b expected 0", c, rec_ina[c][0]); else n_pass++;
            n_chk++;
            if (rec_outv[c] !== 1'b1) $display("FAIL bp_out_v c%0d: got %b expected 1", c, rec_outv[c]); else n_pass++;
            n_chk++;
            if (rec_outd[c] !== word(0, 0)) $display("FAIL bp_out_d c%0d: got %h expected %h", c, rec_outd[c], word(0, 0)); else n_pass++;
            n_chk++;
            if (rec_busy[c] !== 1'b1) $display("FAIL bp_busy c%0d: got %b expected 1", c, rec_busy[c]); else n_pass++;
        end
        n_chk++;
        if (xq.size() != 4) $display("FAIL bp_count: got %0d expected 4", xq.size());
        else begin
            n_pass++;
            for (int k = 0; k < 4; k++) begin
                n_chk++;
                if (xq[k] !== word(0, k)) $display("FAIL bp_word%0d: got %h expected %h", k, xq[k], word(0, k));
                else n_pass++;
            end
        end
        n_chk++; if (src_rd[0] != 4) $display("FAIL bp_src0_taken: got %0d expected 4", src_rd[0]); else n_pass++;
    endtask

    task automatic test_early_end();
        int es[12] = '{0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2};
        int ek[12] = '{0, 1, 0, 2, 3, 4, 5, 6, 7, 8, 9, 1};
        weights[0] = 4'd8;
        weights[1] = 4'd0;
        weights[2] = 4'd1;
        load_src(0, 10);
        load_src(2, 4);
        for (int c = 0; c < 20; c++) begin
            src_en[0] = (c != 3);
            drive_inputs();
            step();
        end
        n_chk++; if (rec_busy[4] !== 1'b0) $display("FAIL ee_idle_c4: got %b expected 0", rec_busy[4]); else n_pass++;
        n_chk++; if (rec_gr[5] !== 2'd2) $display("FAIL ee_grant_c5: got %0d expected 2", rec_gr[5]); else n_pass++;
        n_chk++; if (rec_gr[6] !== 2'd2) $display("FAIL ee_hold_c6: got %0d expected 2", rec_gr[6]); else n_pass++;
        n_chk++; if (rec_gr[7] !== 2'd0) $display("FAIL ee_grant_c7: got %0d expected 0", rec_gr[7]); else n_pass++;
        n_chk++;
        if (xq.size() < 12) $display("FAIL ee_count: got %0d expected at least 12", xq.size());
        else begin
            n_pass++;
            for (int k = 0; k < 12; k++) begin
                n_chk++;
                if (xq[k] !== word(es[k], ek[k])) $display("FAIL ee_word%0d: got %h expected %h", k, xq[k], word(es[k], ek[k]));
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        weights[0] = 4'd1;
        weights[1] = 4'd4;
        weights[2] = 4'd4;
        load_src(0, 1);
        load_src(1, 8);
        load_src(2, 8);
        for (int c = 0; c < 5; c++) begin
            drive_inputs();
            step();
        end
        drive_inputs();
        #2;
        n_chk++; if (out_v !== 1'b1) $display("FAIL rmb_pre_out_v: got %b expected 1", out_v); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL rmb_pre_busy: got %b expected 1", busy); else n_pass++;
        n_chk++; if (cur_grant !== 2'd1) $display("FAIL rmb_pre_grant: got %0d expected 1", cur_grant); else n_pass++;
        reset = 1'b0;
        #1;
        n_chk++; if (out_v !== 1'b0) $display("FAIL rmb_out_v: got %b expected 0", out_v); else n_pass++;
        n_chk++; if (out_d !== '0) $display("FAIL rmb_out_d: got %h expected 0", out_d); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rmb_busy: got %b expected 0", busy); else n_pass++;
        n_chk++; if (in_a !== 3'b000) $display("FAIL rmb_in_a: got %b expected 000", in_a); else n_pass++;
        n_chk++; if (cur_grant !== 2'd0) $display("FAIL rmb_cur_grant: got %0d expected 0", cur_grant); else n_pass++;
        src_mem[0][1] = word(0, 1);
        src_cnt[0]    = 2;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc   = 0;
        xq.delete();
        for (int c = 0; c < 6; c++) begin
            drive_inputs();
            step();
        end
        n_chk++; if (rec_busy[0] !== 1'b0) $display("FAIL rmb_post_idle: got %b expected 0", rec_busy[0]); else n_pass++;
        n_chk++; if (rec_busy[1] !== 1'b1) $display("FAIL rmb_post_busy: got %b expected 1", rec_busy[1]); else n_pass++;
        n_chk++; if (rec_gr[1] !== 2'd0) $display("FAIL rmb_post_grant: got %0d expected 0", rec_gr[1]); else n_pass++;
        n_chk++;
        if (xq.size() < 2) $display("FAIL rmb_post_count: got %0d expected at least 2", xq.size());
        else begin
            n_pass++;
            n_chk++;
            if (xq[0] !== word(0, 1)) $display("FAIL rmb_post_word0: got %h expected %h", xq[0], word(0, 1)); else n_pass++;
            n_chk++;
            if (xq[1] !== word(1, 2)) $display("FAIL rmb_post_word1: got %h expected %h", xq[1], word(1, 2)); else n_pass++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        apply_reset();
        test_single();
        apply_reset();
        test_rotation();
        apply_reset();
        test_zero_weight();
        apply_reset();
        test_backpressure();
        apply_reset();
        test_early_end();
        apply_reset();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
